// File: rtl/dmem_sized_if.sv
// rtl/dmem_sized_if.sv - MEM-stage data memory bus between pipeline (master) and dmem_sized (slave)
interface dmem_sized_if;
    logic        memread;
    logic        memwrite;
    logic [1:0]  size;
    logic        unsigned_ld;
    logic [31:0] addr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        stall;
    logic        misaligned;

    modport master (
        output memread, memwrite, size, unsigned_ld, addr, writedata,
        input  readdata, stall, misaligned
    );

    modport slave (
        input  memread, memwrite, size, unsigned_ld, addr, writedata,
        output readdata, stall, misaligned
    );
endinterface

// File: rtl/dmem_sized.sv
// rtl/dmem_sized.sv - byte/half/word data memory with LATENCY wait states and stall handshake
// Optional misaligned-access trap enabled by defining DMEM_MISALIGN_TRAP_EN.
module dmem_sized #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    dmem_sized_if.slave bus
);
    localparam int         AW       = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = 4'((LATENCY > 0) ? LATENCY - 1 : 0);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t        r_state;
    logic [3:0]    r_cnt;
    logic [AW+1:0] r_addr;
    logic [31:0]   r_wdata;
    logic [1:0]    r_size;
    logic          r_unsigned;
    logic          r_store;
    logic [31:0]   r_readdata;
    logic [31:0]   r_mem [DEPTH];

    logic          w_req;
    logic          w_from_bus;
    logic [AW+1:0] w_addr;
    logic [31:0]   w_wdata;
    logic [1:0]    w_size;
    logic          w_unsigned;
    logic          w_store;
    logic [AW-1:0] w_idx;
    logic [1:0]    w_off;
    logic [3:0]    w_mask;
    logic          w_mis;
    logic [31:0]   w_wlanes;
    logic [31:0]   w_word;
    logic [31:0]   w_shift;
    logic [31:0]   w_load;
    logic          w_commit;
    logic          w_wr_en;
    logic          w_ld_en;
    logic          w_unused_addr;

    assign w_req         = bus.memread | bus.memwrite;
    assign w_unused_addr = ^bus.addr[31:AW+2];

    // With zero latency the commit happens straight out of IDLE, so use the live bus there.
    assign w_from_bus = (r_state == IDLE);
    assign w_addr     = w_from_bus ? bus.addr[AW+1:0] : r_addr;
    assign w_wdata    = w_from_bus ? bus.writedata    : r_wdata;
    assign w_size     = w_from_bus ? bus.size         : r_size;
    assign w_unsigned = w_from_bus ? bus.unsigned_ld  : r_unsigned;
    assign w_store    = w_from_bus ? bus.memwrite     : r_store;
    assign w_idx      = w_addr[AW+1:2];

    always_comb begin
        w_off    = 2'b00;
        w_mask   = 4'hF;
        w_mis    = 1'b0;
        w_wlanes = w_wdata;
        case (w_size)
            2'b00: begin
                w_off    = w_addr[1:0];
                w_mask   = 4'b0001 << w_addr[1:0];
                w_wlanes = {4{w_wdata[7:0]}};
            end
            2'b01: begin
                w_off    = {w_addr[1], 1'b0};
                w_mask   = w_addr[1] ? 4'b1100 : 4'b0011;
                w_wlanes = {2{w_wdata[15:0]}};
            end
            default: begin
                w_off    = 2'b00;
                w_mask   = 4'hF;
                w_wlanes = w_wdata;
            end
        endcase
`ifdef DMEM_MISALIGN_TRAP_EN
        w_mis = ((w_size == 2'b01) && w_addr[0]) ||
                ((w_size == 2'b10) && (w_addr[1:0] != 2'b00)) ||
                (w_size == 2'b11);
`endif
    end

    assign w_word  = r_mem[w_idx];
    assign w_shift = w_word >> {w_off, 3'b000};

    always_comb begin
        case (w_size)
            2'b00:   w_load = w_unsigned ? {24'h0, w_shift[7:0]}
                                         : {{24{w_shift[7]}}, w_shift[7:0]};
            2'b01:   w_load = w_unsigned ? {16'h0, w_shift[15:0]}
                                         : {{16{w_shift[15]}}, w_shift[15:0]};
            default: w_load = w_word;
        endcase
    end

    assign w_commit = !rst && (((r_state == IDLE) && w_req && (LATENCY == 0)) ||
                               ((r_state == WAIT) && (r_cnt == 4'd0)));
    assign w_wr_en  = w_commit &&  w_store && !w_mis;
    assign w_ld_en  = w_commit && !w_store && !w_mis;

    // Memory array is deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (w_mask[b]) begin
                    r_mem[w_idx][b*8 +: 8] <= w_wlanes[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= 4'd0;
            r_addr     <= '0;
            r_wdata    <= 32'h0;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
            r_store    <= 1'b0;
            r_readdata <= 32'h0;
        end else begin
            if (w_ld_en) begin
                r_readdata <= w_load;
            end
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_addr     <= bus.addr[AW+1:0];
                        r_wdata    <= bus.writedata;
                        r_size     <= bus.size;
                        r_unsigned <= bus.unsigned_ld;
                        r_store    <= bus.memwrite;
                        r_cnt      <= CNT_INIT;
                        r_state    <= (LATENCY == 0) ? DONE : WAIT;
                    end
                end
                WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    logic r_misaligned;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_misaligned <= 1'b0;
        end else begin
            r_misaligned <= w_commit && w_mis;
        end
    end

    assign bus.misaligned = r_misaligned;
`else
    assign bus.misaligned = 1'b0;
`endif

    assign bus.readdata = r_readdata;
    assign bus.stall    = !rst && (((r_state == IDLE) && w_req) || (r_state == WAIT));
endmodule
